// File: rtl/fu_branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : fu_branch_resolve_if
// Description : Signal bundle for the branch functional unit. Groups the
//               issue handshake, flush, BTB update side, redirect, writeback
//               handshake and performance counters.
//               slave  : the branch unit (drives in_ready, BTB/redirect/wb/
//                        counter outputs)
//               master : the issue/predictor/writeback environment
// Revision    : 1.0 - initial release
// ============================================================================
interface fu_branch_resolve_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
);
  // Issue side
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_rs1;
  logic [WORD_W-1:0] in_rs2;
  logic [WORD_W-1:0] in_imm;
  logic [2:0]        in_op;
  logic              in_pred_taken;
  logic [WORD_W-1:0] in_pred_target;
  logic              flush;
  // BTB update side
  logic              update_btb;
  logic [WORD_W-1:0] update_pc;
  logic              branch_outcome;
  logic [WORD_W-1:0] branch_target;
  // Redirect
  logic              mispredict;
  logic [WORD_W-1:0] redirect_pc;
  // Writeback
  logic              wb_valid;
  logic              wb_ready;
  logic [WORD_W-1:0] wb_link;
  logic              wb_rd_en;
  // Performance counters
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_op,
           in_pred_taken, in_pred_target, flush, wb_ready,
    output in_ready, update_btb, update_pc, branch_outcome, branch_target,
           mispredict, redirect_pc, wb_valid, wb_link, wb_rd_en,
           branch_count, mispredict_count
  );

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_op,
           in_pred_taken, in_pred_target, flush, wb_ready,
    input  in_ready, update_btb, update_pc, branch_outcome, branch_target,
           mispredict, redirect_pc, wb_valid, wb_link, wb_rd_en,
           branch_count, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/fu_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : fu_branch_resolve
// Description : Execute-stage branch unit. S1 registers the issued operands
//               and resolves taken/target combinationally; S2 holds the
//               result for writeback and, in its first cycle, strobes the
//               BTB update and a redirect on misprediction.
// Ports       : CLK  - clock
//               nRST - asynchronous active-low reset
//               bus  - fu_branch_resolve_if.slave (issue, flush, BTB update,
//                      redirect, writeback handshake, counters)
// Revision    : 1.0 - initial release
// ============================================================================
module fu_branch_resolve #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
) (
  input wire logic           CLK,
  input wire logic           nRST,
  fu_branch_resolve_if.slave bus
);

  localparam logic [2:0] c_OP_BEQ  = 3'b000;
  localparam logic [2:0] c_OP_BNE  = 3'b001;
  localparam logic [2:0] c_OP_JAL  = 3'b010;
  localparam logic [2:0] c_OP_JALR = 3'b011;
  localparam logic [2:0] c_OP_BLT  = 3'b100;
  localparam logic [2:0] c_OP_BGE  = 3'b101;
  localparam logic [2:0] c_OP_BLTU = 3'b110;
  localparam logic [2:0] c_OP_BGEU = 3'b111;

  // S1: operand register
  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_pc, r_s1_rs1, r_s1_rs2, r_s1_imm, r_s1_pred_target;
  logic [2:0]        r_s1_op;
  logic              r_s1_pred_taken;

  // S2: result register
  logic              r_s2_valid, r_s2_new;
  logic [WORD_W-1:0] r_s2_pc, r_s2_target, r_s2_link, r_s2_pred_target;
  logic              r_s2_taken, r_s2_rd_en, r_s2_pred_taken;

  logic [CNT_W-1:0]  r_branch_count, r_mispredict_count;

  logic              w_taken, w_rd_en;
  logic [WORD_W-1:0] w_pc_sum, w_reg_sum, w_target;
  logic              w_update, w_mispredict;
  logic              w_s1_adv, w_in_ready, w_accept, w_s2_load;

  // Resolution of the op sitting in S1
  always_comb begin
    w_taken = 1'b0;
    case (r_s1_op)
      c_OP_BEQ:  w_taken = (r_s1_rs1 == r_s1_rs2);
      c_OP_BNE:  w_taken = (r_s1_rs1 != r_s1_rs2);
      c_OP_BLT:  w_taken = ($signed(r_s1_rs1) <  $signed(r_s1_rs2));
      c_OP_BGE:  w_taken = ($signed(r_s1_rs1) >= $signed(r_s1_rs2));
      c_OP_BLTU: w_taken = (r_s1_rs1 <  r_s1_rs2);
      c_OP_BGEU: w_taken = (r_s1_rs1 >= r_s1_rs2);
      c_OP_JAL:  w_taken = 1'b1;
      c_OP_JALR: w_taken = 1'b1;
    endcase
  end

  assign w_pc_sum  = r_s1_pc + r_s1_imm;
  assign w_reg_sum = r_s1_rs1 + r_s1_imm;
  // JALR clears bit 0 of the computed address
  assign w_target  = (r_s1_op == c_OP_JALR) ? {w_reg_sum[WORD_W-1:1], 1'b0} : w_pc_sum;
  assign w_rd_en   = (r_s1_op == c_OP_JAL) || (r_s1_op == c_OP_JALR);

  // An S2 entry reports to the predictor only in its first cycle, so a
  // writeback stall never repeats the BTB write or the redirect.
  assign w_update     = r_s2_valid && r_s2_new;
  // A correctly predicted not-taken op ignores the predicted target.
  assign w_mispredict = w_update &&
                        ((r_s2_taken != r_s2_pred_taken) ||
                         (r_s2_taken && (r_s2_target != r_s2_pred_target)));

  assign w_s1_adv   = !r_s2_valid || bus.wb_ready;
  assign w_in_ready = !bus.flush && !w_mispredict && (!r_s1_valid || w_s1_adv);
  assign w_accept   = bus.in_valid && w_in_ready;
  // S1 holds a younger wrong-path op during a redirect, so it must not reach S2
  assign w_s2_load  = r_s1_valid && w_s1_adv && !w_mispredict && !bus.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_s1_valid       <= 1'b0;
      r_s1_pc          <= '0;
      r_s1_rs1         <= '0;
      r_s1_rs2         <= '0;
      r_s1_imm         <= '0;
      r_s1_op          <= '0;
      r_s1_pred_taken  <= 1'b0;
      r_s1_pred_target <= '0;
    end else begin
      if (bus.flush || w_mispredict) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_accept) begin
        r_s1_pc          <= bus.in_pc;
        r_s1_rs1         <= bus.in_rs1;
        r_s1_rs2         <= bus.in_rs2;
        r_s1_imm         <= bus.in_imm;
        r_s1_op          <= bus.in_op;
        r_s1_pred_taken  <= bus.in_pred_taken;
        r_s1_pred_target <= bus.in_pred_target;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_s2_valid       <= 1'b0;
      r_s2_new         <= 1'b0;
      r_s2_pc          <= '0;
      r_s2_taken       <= 1'b0;
      r_s2_target      <= '0;
      r_s2_link        <= '0;
      r_s2_rd_en       <= 1'b0;
      r_s2_pred_taken  <= 1'b0;
      r_s2_pred_target <= '0;
    end else begin
      if (bus.flush) begin
        r_s2_valid <= 1'b0;
        r_s2_new   <= 1'b0;
      end else if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_new   <= 1'b1;
      end else begin
        if (r_s2_valid && bus.wb_ready) begin
          r_s2_valid <= 1'b0;
        end
        r_s2_new <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_pc          <= r_s1_pc;
        r_s2_taken       <= w_taken;
        r_s2_target      <= w_target;
        r_s2_link        <= r_s1_pc + WORD_W'(4);
        r_s2_rd_en       <= w_rd_en;
        r_s2_pred_taken  <= r_s1_pred_taken;
        r_s2_pred_target <= r_s1_pred_target;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_update && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (w_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.update_btb       = w_update;
  assign bus.update_pc        = r_s2_pc;
  assign bus.branch_outcome   = r_s2_taken;
  assign bus.branch_target    = r_s2_target;
  assign bus.mispredict       = w_mispredict;
  assign bus.redirect_pc      = r_s2_taken ? r_s2_target : r_s2_link;
  assign bus.wb_valid         = r_s2_valid;
  assign bus.wb_link          = r_s2_link;
  assign bus.wb_rd_en         = r_s2_rd_en;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_fu_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_branch_resolve
// Description : Self-checking bench for fu_branch_resolve. Accepted ops are
//               resolved by a behavioural model and queued; a monitor pops
//               the queue on every BTB update and checks the predictor,
//               redirect, writeback and counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_branch_resolve;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        rd_en;
    logic        mis;
    logic [31:0] redirect;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  exp_t        q[$];
  exp_t        cur;
  bit          cur_valid;
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  fu_branch_resolve_if #(.WORD_W(32), .CNT_W(32)) bus ();

  fu_branch_resolve #(.WORD_W(32), .CNT_W(32)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Architectural meaning of each op, straight from the ISA rules
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic pt,
                                 input logic [31:0] ptgt);
    exp_t e;
    int   s1, s2;
    s1 = rs1;
    s2 = rs2;
    case (op)
      3'd0:    e.taken = (rs1 == rs2);
      3'd1:    e.taken = (rs1 != rs2);
      3'd4:    e.taken = (s1 < s2);
      3'd5:    e.taken = !(s1 < s2);
      3'd6:    e.taken = (rs1 < rs2);
      3'd7:    e.taken = !(rs1 < rs2);
      default: e.taken = 1'b1;
    endcase
    e.pc       = pc;
    e.target   = (op == 3'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.link     = pc + 32'd4;
    e.rd_en    = (op == 3'd2) || (op == 3'd3);
    e.mis      = (e.taken != pt) || (e.taken && (e.target != ptgt));
    e.redirect = e.taken ? e.target : e.link;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      cur_valid = 0;
      exp_bc    = 0;
      exp_mc    = 0;
    end else begin
      chk("branch_count", bus.branch_count, exp_bc);
      chk("mispredict_count", bus.mispredict_count, exp_mc);
      if (bus.update_btb) begin
        if (q.size() == 0) begin
          chk("unexpected_update_btb", 32'(bus.update_btb), 32'd0);
        end else begin
          e = q.pop_front();
          chk("s2_reload_before_retire", 32'(cur_valid), 32'd0);
          cur       = e;
          cur_valid = 1;
          chk("update_pc", bus.update_pc, e.pc);
          chk("branch_outcome", 32'(bus.branch_outcome), 32'(e.taken));
          chk("branch_target", bus.branch_target, e.target);
          chk("mispredict", 32'(bus.mispredict), 32'(e.mis));
          if (e.mis) begin
            chk("redirect_pc", bus.redirect_pc, e.redirect);
            exp_mc = exp_mc + 1;
            // a redirect kills every younger op still in flight
            q.delete();
          end
          exp_bc = exp_bc + 1;
        end
      end else begin
        chk("mispredict_idle", 32'(bus.mispredict), 32'd0);
      end
      chk("wb_valid", 32'(bus.wb_valid), 32'(cur_valid));
      if (cur_valid && bus.wb_valid) begin
        chk("wb_link", bus.wb_link, cur.link);
        chk("wb_rd_en", 32'(bus.wb_rd_en), 32'(cur.rd_en));
      end
      if (bus.wb_valid && bus.wb_ready) cur_valid = 0;
      if (bus.flush) begin
        q.delete();
        cur_valid = 0;
      end
    end
  end

  task automatic drive_op(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                          input logic [31:0] ptgt);
    bus.in_op          = op;
    bus.in_pc          = pc;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_imm         = imm;
    bus.in_pred_taken  = pt;
    bus.in_pred_target = ptgt;
  endtask

  // Waits to mid-cycle; if the op is taken this cycle, queue its expectation
  task automatic sample_accept(output bit acc);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) q.push_back(model(bus.in_op, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm,
                               bus.in_pred_taken, bus.in_pred_target));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt);
    bit acc;
    acc = 0;
    drive_op(op, pc, rs1, rs2, imm, pt, ptgt);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      sample_accept(acc);
      next_cycle();
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Random op on the bus; correct=1 makes the prediction match the model
  task automatic drive_random(input bit correct);
    logic [2:0]  ops[8];
    logic [2:0]  op;
    logic [31:0] pc, rs1, rs2, imm, ptgt;
    logic        pt;
    exp_t        e;
    ops  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    op   = ops[$urandom_range(0, 7)];
    pc   = $urandom & 32'hFFFF_FFFC;
    rs1  = rand_operand();
    rs2  = ($urandom_range(0, 3) == 0) ? rs1 : rand_operand();
    imm  = 32'($signed($urandom_range(0, 1023)) - 512);
    e    = model(op, pc, rs1, rs2, imm, 1'b0, 32'd0);
    if (correct || $urandom_range(0, 3) != 0) begin
      pt   = e.taken;
      ptgt = ($urandom_range(0, 1) == 0 && !e.taken) ? $urandom : e.target;
    end else begin
      pt   = $urandom_range(0, 1) == 1;
      ptgt = ($urandom_range(0, 1) == 0) ? e.target : $urandom;
    end
    drive_op(op, pc, rs1, rs2, imm, pt, ptgt);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    bit acc;
    int idx;
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b1;
    drive_op(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    repeat (3) next_cycle();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_update_btb", 32'(bus.update_btb), 32'd0);
    chk("reset_mispredict", 32'(bus.mispredict), 32'd0);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_branch_count", bus.branch_count, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Directed ops
    issue(3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120);        // BEQ correct
    repeat (3) next_cycle();
    issue(3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'd0); // BLT mispredict
    issue(3'd0, 32'h500, 32'd1, 32'd1, 32'h8, 1'b1, 32'h508);        // killed younger op
    repeat (3) next_cycle();
    issue(3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240); // BLTU not taken
    repeat (3) next_cycle();
    issue(3'd3, 32'h300, 32'h1001, 32'd0, 32'd2, 1'b1, 32'h1000);   // JALR
    repeat (3) next_cycle();

    // Writeback stall: only two of three ops fit
    do_reset();
    bus.wb_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        drive_random(1'b1);
        bus.in_valid = 1'b1;
      end
      sample_accept(acc);
      next_cycle();
      if (acc) begin
        idx++;
        bus.in_valid = 1'b0;
      end
    end
    chk("stall_accept_count", 32'(idx), 32'd2);
    bus.wb_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 3; c++) begin
      drive_random(1'b1);
      bus.in_valid = 1'b1;
      sample_accept(acc);
      next_cycle();
      bus.in_valid = 1'b0;
      if (acc) idx++;
    end
    repeat (5) next_cycle();
    chk("stall_branch_count", bus.branch_count, 32'd3);

    // Flush with S1 and S2 occupied
    bus.wb_ready = 1'b0;
    drive_random(1'b1);
    issue(bus.in_op, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_pred_taken, bus.in_pred_target);
    drive_random(1'b1);
    issue(bus.in_op, bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_pred_taken, bus.in_pred_target);
    bus.flush = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    chk("flush_wb_valid", 32'(bus.wb_valid), 32'd0);
    repeat (4) next_cycle();
    bus.wb_ready = 1'b1;

    // Randomized traffic with backpressure and occasional flushes
    for (int c = 0; c < 400; c++) begin
      drive_random(1'b0);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 49) == 0);
      sample_accept(acc);
      next_cycle();
    end

    // Asynchronous reset in the middle of traffic
    for (int c = 0; c < 6; c++) begin
      drive_random(1'b1);
      bus.in_valid = 1'b1;
      bus.wb_ready = 1'b0;
      bus.flush    = 1'b0;
      sample_accept(acc);
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_update_btb", 32'(bus.update_btb), 32'd0);
    chk("async_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("async_rst_branch_count", bus.branch_count, 32'd0);
    chk("async_rst_mispredict_count", bus.mispredict_count, 32'd0);
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;

    // Short random run after reset, then drain
    for (int c = 0; c < 100; c++) begin
      drive_random(1'b0);
      bus.in_valid = ($urandom_range(0, 9) < 8);
      bus.wb_ready = ($urandom_range(0, 4) != 0);
      sample_accept(acc);
      next_cycle();
    end
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    repeat (8) next_cycle();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("wb_drained", 32'(bus.wb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
